// File: rtl/riscv_core_vec_seq_ctrl_pkg.sv
// Shared definitions for the vector sequencer: op encodings, register geometry
// and FSM state encoding.
package riscv_core_vec_seq_ctrl_pkg;

    localparam int VEC_ELEM_W = 8;
    localparam int VEC_REG_W  = 256;
    localparam int VEC_VLMAX  = VEC_REG_W / VEC_ELEM_W;

    localparam logic [1:0] VEC_OP_VV    = 2'd0;
    localparam logic [1:0] VEC_OP_SETVL = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WB    = 3'd3,
        ST_SETV  = 3'd4
    } vec_state_e;

endpackage

// File: rtl/riscv_core_vec_seq_ctrl_elem_en.sv
// Element-enable generation: which of the 32 elements the op touches, and the
// LANES-wide slice of that vector for the current beat.
module riscv_core_vec_elem_en #(
    parameter int LANES = 8
) (
    input  logic [5:0]       vl,
    input  logic [31:0]      mask,
    input  logic             masked,
    input  logic [1:0]       beat_idx,
    output logic [31:0]      active,
    output logic [LANES-1:0] slice
);

    always_comb begin
        active = '0;
        for (int i = 0; i < 32; i++) begin
            active[i] = (6'(i) < vl) && (!masked || mask[i]);
        end
    end

    always_comb begin
        slice = active[int'(beat_idx) * LANES +: LANES];
    end

endmodule

// File: rtl/riscv_core_vec_seq_ctrl.sv
// Multi-cycle vector op sequencer: beats a LANES-wide FU over the active
// elements, drains the FU pipeline, then issues one masked regfile write.
module riscv_core_vec_seq_ctrl
    import riscv_core_vec_seq_ctrl_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int FU_LAT = 2,
    parameter int VLMAX  = VEC_VLMAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_val,
    output logic             op_rdy,
    input  logic [1:0]       op_type,
    input  logic [4:0]       op_vd,
    input  logic [4:0]       op_vs1,
    input  logic [4:0]       op_vs2,
    input  logic             op_masked,
    input  logic [31:0]      op_avl,
    input  logic [5:0]       vl,
    input  logic [31:0]      mask,
    output logic [4:0]       raddr0,
    output logic [4:0]       raddr1,
    output logic             beat_val,
    output logic [1:0]       beat_idx,
    output logic [LANES-1:0] beat_en,
    output logic             wen_p,
    output logic [4:0]       waddr_p,
    output logic [31:0]      elem_wen,
    output logic             wvlen_p,
    output logic [5:0]       wvl_p,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    localparam int DW = (FU_LAT > 1) ? $clog2(FU_LAT) : 1;

    // Handshake: an op transfers on the rising edge where op_val && op_rdy;
    // op_rdy is high only in IDLE and does not depend on op_val.
    vec_state_e        state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [4:0]        vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
    logic              masked_q, masked_d;
    logic [31:0]       avl_q, avl_d;
    logic [5:0]        vl_q, vl_d;
    logic [31:0]       mask_q, mask_d;

    logic [31:0]       active;
    logic [LANES-1:0]  slice;
    logic [5:0]        vl_eff;
    logic              last_beat;

    riscv_core_vec_elem_en #(.LANES(LANES)) u_elem_en (
        .vl       (vl_q),
        .mask     (mask_q),
        .masked   (masked_q),
        .beat_idx (beat_q),
        .active   (active),
        .slice    (slice)
    );

    // A vl above VLMAX must not run the beat counter past the register.
    assign vl_eff    = (vl_q > 6'(VLMAX)) ? 6'(VLMAX) : vl_q;
    assign last_beat = (({30'd0, beat_q} + 32'd1) * 32'(LANES)) >= {26'd0, vl_eff};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            drain_q  <= '0;
            vd_q     <= '0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            masked_q <= 1'b0;
            avl_q    <= '0;
            vl_q     <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            drain_q  <= drain_d;
            vd_q     <= vd_d;
            vs1_q    <= vs1_d;
            vs2_q    <= vs2_d;
            masked_q <= masked_d;
            avl_q    <= avl_d;
            vl_q     <= vl_d;
            mask_q   <= mask_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        drain_d  = drain_q;
        vd_d     = vd_q;
        vs1_d    = vs1_q;
        vs2_d    = vs2_q;
        masked_d = masked_q;
        avl_d    = avl_q;
        vl_d     = vl_q;
        mask_d   = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (op_val) begin
                    vd_d     = op_vd;
                    vs1_d    = op_vs1;
                    vs2_d    = op_vs2;
                    masked_d = op_masked;
                    avl_d    = op_avl;
                    vl_d     = vl;
                    mask_d   = mask;
                    beat_d   = '0;
                    drain_d  = '0;
                    if (op_type == VEC_OP_SETVL) begin
                        state_d = ST_SETV;
                    end else if (vl == 6'd0) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_BEAT;
                    end
                end
            end
            ST_BEAT: begin
                if (last_beat) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DW'(FU_LAT - 1)) begin
                    state_d = ST_WB;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_WB:   state_d = ST_IDLE;
            ST_SETV: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_rdy   = 1'b0;
        busy     = 1'b0;
        raddr0   = '0;
        raddr1   = '0;
        beat_val = 1'b0;
        beat_idx = '0;
        beat_en  = '0;
        wen_p    = 1'b0;
        waddr_p  = '0;
        elem_wen = '0;
        wvlen_p  = 1'b0;
        wvl_p    = '0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: op_rdy = 1'b1;
            ST_BEAT: begin
                beat_val = 1'b1;
                beat_idx = beat_q;
                beat_en  = slice;
            end
            ST_WB: begin
                wen_p    = 1'b1;
                waddr_p  = vd_q;
                elem_wen = active;
                done     = 1'b1;
            end
            ST_SETV: begin
                wvlen_p = 1'b1;
                wvl_p   = (avl_q > 32'(VLMAX)) ? 6'(VLMAX) : avl_q[5:0];
                done    = 1'b1;
            end
            default: ;
        endcase
        if (state_q != ST_IDLE) begin
            busy   = 1'b1;
            raddr0 = vs1_q;
            raddr1 = vs2_q;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_riscv_core_vec_seq_ctrl.sv
// Directed bench for the vector sequencer: a driver issues ops and queues the
// expected beats/writes; a monitor pops and compares whenever the DUT acts.
module tb_riscv_core_vec_seq_ctrl;

  localparam int LANES  = 8;
  localparam int FU_LAT = 2;
  localparam logic [1:0] K_BEAT = 2'd0;
  localparam logic [1:0] K_WB   = 2'd1;
  localparam logic [1:0] K_SETV = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] cyc;
    logic [5:0]  a;
    logic [31:0] data;
    logic [4:0]  r0;
    logic [4:0]  r1;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             op_val = 1'b0;
  logic             op_rdy;
  logic [1:0]       op_type = '0;
  logic [4:0]       op_vd = '0, op_vs1 = '0, op_vs2 = '0;
  logic             op_masked = 1'b0;
  logic [31:0]      op_avl = '0;
  logic [5:0]       vl = '0;
  logic [31:0]      mask = '0;
  logic [4:0]       raddr0, raddr1;
  logic             beat_val;
  logic [1:0]       beat_idx;
  logic [LANES-1:0] beat_en;
  logic             wen_p;
  logic [4:0]       waddr_p;
  logic [31:0]      elem_wen;
  logic             wvlen_p;
  logic [5:0]       wvl_p;
  logic             busy, done;
  logic [2:0]       dbg_state;

  exp_t exp_q[$];
  int   cmp_cnt  = 0;
  int   fail_cnt = 0;
  int   cyc      = 0;
  int   last_wb  = 0;
  logic prev_done = 1'b0;

  riscv_core_vec_seq_ctrl #(.LANES(LANES), .FU_LAT(FU_LAT), .VLMAX(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_val    (op_val),
    .op_rdy    (op_rdy),
    .op_type   (op_type),
    .op_vd     (op_vd),
    .op_vs1    (op_vs1),
    .op_vs2    (op_vs2),
    .op_masked (op_masked),
    .op_avl    (op_avl),
    .vl        (vl),
    .mask      (mask),
    .raddr0    (raddr0),
    .raddr1    (raddr1),
    .beat_val  (beat_val),
    .beat_idx  (beat_idx),
    .beat_en   (beat_en),
    .wen_p     (wen_p),
    .waddr_p   (waddr_p),
    .elem_wen  (elem_wen),
    .wvlen_p   (wvlen_p),
    .wvl_p     (wvl_p),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // expected-response model for one accepted op
  task automatic push_exp(input logic [1:0] ty, input logic [4:0] vd, vs1, vs2,
                          input logic m, input logic [31:0] avl, input int t);
    exp_t e;
    logic [31:0] act;
    int vle, nb;
    act = '0;
    for (int i = 0; i < 32; i++) act[i] = (i < int'(vl)) && (!m || mask[i]);
    e.r0 = vs1;
    e.r1 = vs2;
    if (ty == 2'd1) begin
      e.kind = K_SETV;
      e.cyc  = 32'(t + 1);
      e.a    = (avl > 32'd32) ? 6'd32 : avl[5:0];
      e.data = '0;
      exp_q.push_back(e);
      return;
    end
    vle = (int'(vl) > 32) ? 32 : int'(vl);
    nb  = (vle + LANES - 1) / LANES;
    for (int b = 0; b < nb; b++) begin
      e.kind = K_BEAT;
      e.cyc  = 32'(t + 1 + b);
      e.a    = 6'(b);
      e.data = {24'd0, act[b*LANES +: LANES]};
      exp_q.push_back(e);
    end
    e.kind  = K_WB;
    e.cyc   = (nb == 0) ? 32'(t + 1) : 32'(t + nb + FU_LAT + 1);
    e.a     = {1'b0, vd};
    e.data  = act;
    last_wb = int'(e.cyc);
    exp_q.push_back(e);
  endtask

  // driver: present op, wait for op_rdy, record accept cycle
  task automatic issue(input logic [1:0] ty, input logic [4:0] vd, vs1, vs2,
                       input logic m, input logic [31:0] avl, input bit hold,
                       output int t);
    int n;
    @(negedge clk);
    op_type = ty; op_vd = vd; op_vs1 = vs1; op_vs2 = vs2;
    op_masked = m; op_avl = avl; op_val = 1'b1;
    n = 0;
    while (!op_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!op_rdy) begin
      cmp_cnt++; fail_cnt++;
      $display("FAIL accept_timeout: op_rdy=%0b expected 1 within 200 cycles", op_rdy);
      op_val = 1'b0;
      t = -1;
      return;
    end
    t = cyc;
    push_exp(ty, vd, vs1, vs2, m, avl, t);
    @(posedge clk);
    #1;
    if (!hold) op_val = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] k;
    if (!reset) begin
      chk("done_vs_write", {31'd0, done}, {31'd0, wen_p | wvlen_p});
      if (done && prev_done) chk("done_consecutive", {31'd0, done}, 32'd0);
      prev_done = done;
      if (beat_val || wen_p || wvlen_p) begin
        k = beat_val ? K_BEAT : (wen_p ? K_WB : K_SETV);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {30'd0, k}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("kind", {30'd0, k}, {30'd0, e.kind});
          chk("cycle", 32'(cyc), e.cyc);
          chk("raddr0", {27'd0, raddr0}, {27'd0, e.r0});
          chk("raddr1", {27'd0, raddr1}, {27'd0, e.r1});
          case (e.kind)
            K_BEAT: begin
              chk("beat_idx", {30'd0, beat_idx}, {26'd0, e.a});
              chk("beat_en", {24'd0, beat_en}, e.data);
            end
            K_WB: begin
              chk("waddr_p", {27'd0, waddr_p}, {26'd0, e.a});
              chk("elem_wen", elem_wen, e.data);
              chk("wb_no_wvlen", {31'd0, wvlen_p}, 32'd0);
            end
            default: begin
              chk("wvl_p", {26'd0, wvl_p}, {26'd0, e.a});
              chk("setv_no_wen", {31'd0, wen_p}, 32'd0);
            end
          endcase
        end
      end
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic check_idle_outputs(input string name);
    chk({name, "_op_rdy"}, {31'd0, op_rdy}, 32'd1);
    chk({name, "_outs"}, {24'd0, busy, beat_val, wen_p, wvlen_p, done, 3'd0}, 32'd0);
    chk({name, "_vec"}, {raddr0, raddr1, beat_en, beat_idx, waddr_p, wvl_p, 1'b0}, 32'd0);
    chk({name, "_elem_wen"}, elem_wen, 32'd0);
    chk({name, "_state"}, {29'd0, dbg_state}, 32'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || !op_rdy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int t, t2, wb1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check_idle_outputs("reset");

    // full-length unmasked VV
    vl = 6'd32; mask = 32'h0;
    issue(2'd0, 5'd3, 5'd4, 5'd5, 1'b0, 32'd0, 1'b0, t);
    // masked VV with a partial last beat
    vl = 6'd11; mask = 32'h0000_0555;
    issue(2'd0, 5'd7, 5'd8, 5'd9, 1'b1, 32'd0, 1'b0, t);
    // SETVL clamping and passthrough, including a huge unsigned avl
    issue(2'd1, 5'd0, 5'd1, 5'd2, 1'b0, 32'd100, 1'b0, t);
    issue(2'd1, 5'd0, 5'd1, 5'd2, 1'b0, 32'd5, 1'b0, t);
    issue(2'd1, 5'd0, 5'd3, 5'd4, 1'b0, 32'hFFFF_FFFF, 1'b0, t);
    issue(2'd1, 5'd0, 5'd3, 5'd4, 1'b0, 32'd32, 1'b0, t);
    // vl=0 goes straight to a write with an empty element mask
    vl = 6'd0; mask = 32'hFFFF_FFFF;
    issue(2'd0, 5'd6, 5'd10, 5'd11, 1'b0, 32'd0, 1'b0, t);
    // reserved op_type behaves as VV
    vl = 6'd9; mask = 32'hFFFF_FFFF;
    issue(2'd3, 5'd12, 5'd13, 5'd14, 1'b1, 32'd0, 1'b0, t);
    // write to vd=0 still asserts wen_p
    vl = 6'd8; mask = 32'h0;
    issue(2'd2, 5'd0, 5'd15, 5'd16, 1'b0, 32'd0, 1'b0, t);
    wait_drain();

    // op_val held through an op while vl/mask inputs change
    vl = 6'd16; mask = 32'h0000_F0F0;
    issue(2'd0, 5'd9, 5'd1, 5'd2, 1'b1, 32'd0, 1'b1, t);
    wb1 = last_wb;
    @(negedge clk);
    vl = 6'd5; mask = 32'h0;
    issue(2'd0, 5'd10, 5'd17, 5'd18, 1'b0, 32'd0, 1'b0, t2);
    chk("held_accept_cycle", 32'(t2), 32'(wb1 + 1));
    wait_drain();

    // reset during DRAIN kills the op without any write
    vl = 6'd32; mask = 32'h0;
    issue(2'd0, 5'd12, 5'd19, 5'd20, 1'b0, 32'd0, 1'b0, t);
    while (cyc < t + 5 + 1) @(negedge clk);
    chk("pre_reset_state_drain", {29'd0, dbg_state}, 32'd2);
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_idle_outputs("post_reset");

    // sequencer still works after the aborted op
    vl = 6'd24; mask = 32'h00FF_00FF;
    issue(2'd0, 5'd21, 5'd22, 5'd23, 1'b1, 32'd0, 1'b0, t);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    cmp_cnt++; fail_cnt++;
    $display("FAIL global_timeout: simulation time limit reached, queue depth %0d", exp_q.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
